// File: rtl/packet_pkg.sv
// rtl/packet_pkg.sv - shared constants and FSM encoding for the packet arbiter
package packet_pkg;

    localparam int WORD_SIZE_DEFAULT = 64;
    localparam int MODE_RR           = 0;
    localparam int MODE_PRIO         = 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_select.sv
// rtl/rr_select.sv - combinational round-robin / fixed-priority request selector
module rr_select #(
    parameter int CHANNELS = 4
) (
    input  logic [CHANNELS-1:0]         req,
    input  logic [$clog2(CHANNELS)-1:0] last,
    input  logic                        mode,
    output logic                        valid,
    output logic [$clog2(CHANNELS)-1:0] index
);

    localparam int IDX_W = $clog2(CHANNELS);

    logic [IDX_W-1:0] w_cand;

    // mode=1: scan from 0; mode=0: scan from last+1 with wrap. First hit wins.
    always_comb begin
        w_cand = '0;
        valid  = 1'b0;
        index  = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            w_cand = mode ? IDX_W'(k) : IDX_W'((int'(last) + 1 + k) % CHANNELS);
            if (!valid && req[w_cand]) begin
                valid = 1'b1;
                index = w_cand;
            end
        end
    end

endmodule

// File: rtl/packet_arbiter.sv
// rtl/packet_arbiter.sv - packet-atomic merge of CHANNELS show-ahead FIFO streams
module packet_arbiter
    import packet_pkg::*;
#(
    parameter int CHANNELS  = 4,
    parameter int WORD_SIZE = WORD_SIZE_DEFAULT,
    parameter int MODE      = MODE_RR,
    parameter int MAX_WORDS = 4096
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [CHANNELS-1:0]           in_nempty,
    input  logic [CHANNELS*WORD_SIZE-1:0] in_data,
    input  logic [CHANNELS-1:0]           in_end,
    output logic [CHANNELS-1:0]           in_pop,
    input  logic [CHANNELS-1:0]           chan_enable,
    output logic                          out_nempty,
    output logic [WORD_SIZE-1:0]          out_data,
    output logic                          out_end,
    output logic [$clog2(CHANNELS)-1:0]   out_channel,
    input  logic                          out_pop,
    output logic [15:0]                   trunc_count
);

    localparam int IDX_W = $clog2(CHANNELS);
    localparam int WC_W  = $clog2(MAX_WORDS + 1);

    arb_state_t           r_state;
    logic [IDX_W-1:0]     r_grant;
    logic [IDX_W-1:0]     r_last;
    logic [WC_W-1:0]      r_wcount;
    logic                 r_out_valid;
    logic [WORD_SIZE-1:0] r_out_data;
    logic                 r_out_end;
    logic [IDX_W-1:0]     r_out_chan;
    logic [15:0]          r_trunc;

    logic [CHANNELS-1:0]  w_req;
    logic                 w_sel_valid;
    logic [IDX_W-1:0]     w_sel_index;
    logic                 w_load_ok;
    logic                 w_pop_fire;
    logic [WORD_SIZE-1:0] w_sel_data;
    logic                 w_sel_end;
    logic                 w_at_limit;
    logic                 w_pkt_done;
    logic                 w_trunc;

    assign w_req = chan_enable & in_nempty;

    rr_select #(
        .CHANNELS (CHANNELS)
    ) u_rr_select (
        .req   (w_req),
        .last  (r_last),
        .mode  (MODE == MODE_PRIO),
        .valid (w_sel_valid),
        .index (w_sel_index)
    );

    assign w_load_ok  = !r_out_valid || out_pop;
    assign w_pop_fire = (r_state == ST_BUSY) && in_nempty[r_grant] && w_load_ok;
    assign w_sel_data = in_data[int'(r_grant) * WORD_SIZE +: WORD_SIZE];
    assign w_sel_end  = in_end[r_grant];

    // Oversize guard: the MAX_WORDS-th word always closes the packet.
    assign w_at_limit = (r_wcount == WC_W'(MAX_WORDS - 1));
    assign w_pkt_done = w_sel_end || w_at_limit;
    assign w_trunc    = w_at_limit && !w_sel_end;

    always_comb begin
        in_pop = '0;
        if (w_pop_fire) begin
            in_pop[r_grant] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_grant     <= '0;
            r_last      <= IDX_W'(CHANNELS - 1);
            r_wcount    <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_end   <= 1'b0;
            r_out_chan  <= '0;
            r_trunc     <= '0;
        end else begin
            if (w_load_ok) begin
                r_out_valid <= w_pop_fire;
            end
            if (w_pop_fire) begin
                r_out_data <= w_sel_data;
                r_out_end  <= w_pkt_done;
                r_out_chan <= r_grant;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_sel_valid) begin
                        r_grant <= w_sel_index;
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (w_pop_fire) begin
                        if (w_pkt_done) begin
                            r_last   <= r_grant;
                            r_wcount <= '0;
                            r_state  <= ST_IDLE;
                        end else begin
                            r_wcount <= r_wcount + 1'b1;
                        end
                        if (w_trunc && (r_trunc != 16'hFFFF)) begin
                            r_trunc <= r_trunc + 16'd1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign out_nempty  = r_out_valid;
    assign out_data    = r_out_data;
    assign out_end     = r_out_end;
    assign out_channel = r_out_chan;
    assign trunc_count = r_trunc;

endmodule

// File: tb/tb_packet_arbiter.sv
// tb/tb_packet_arbiter.sv - directed self-checking bench for packet_arbiter
module tb_packet_arbiter;

    localparam int CH = 4;
    localparam int W  = 16;

    logic clk = 1'b0;
    logic rst_n;

    logic [CH-1:0]   in_ne  [2];
    logic [CH*W-1:0] in_dat [2];
    logic [CH-1:0]   in_e   [2];
    logic [CH-1:0]   in_p   [2];
    logic [CH-1:0]   ena    [2];
    logic            onem   [2];
    logic [W-1:0]    odat   [2];
    logic            oend   [2];
    logic [1:0]      ochan  [2];
    logic            opop   [2];
    logic [15:0]     trc    [2];

    logic [W-1:0] sd [2][CH][64];
    logic         se [2][CH][64];
    int           slen  [2][CH] = '{default: 0};
    int           shead [2][CH] = '{default: 0};

    logic [31:0]  rx_w [2][128];
    int           rx_cnt [2] = '{default: 0};
    logic [31:0]  exp_q [$];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    packet_arbiter #(.CHANNELS(CH), .WORD_SIZE(W), .MODE(0), .MAX_WORDS(4)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .in_nempty(in_ne[0]), .in_data(in_dat[0]), .in_end(in_e[0]), .in_pop(in_p[0]),
        .chan_enable(ena[0]),
        .out_nempty(onem[0]), .out_data(odat[0]), .out_end(oend[0]), .out_channel(ochan[0]),
        .out_pop(opop[0]), .trunc_count(trc[0])
    );

    packet_arbiter #(.CHANNELS(CH), .WORD_SIZE(W), .MODE(1), .MAX_WORDS(4096)) u_pr (
        .clk(clk), .rst_n(rst_n),
        .in_nempty(in_ne[1]), .in_data(in_dat[1]), .in_end(in_e[1]), .in_pop(in_p[1]),
        .chan_enable(ena[1]),
        .out_nempty(onem[1]), .out_data(odat[1]), .out_end(oend[1]), .out_channel(ochan[1]),
        .out_pop(opop[1]), .trunc_count(trc[1])
    );

    // Show-ahead source FIFOs
    always_comb begin
        for (int d = 0; d < 2; d++) begin
            in_ne[d]  = '0;
            in_e[d]   = '0;
            in_dat[d] = '0;
            for (int c = 0; c < CH; c++) begin
                in_ne[d][c]         = shead[d][c] < slen[d][c];
                in_dat[d][c*W +: W] = sd[d][c][shead[d][c] % 64];
                in_e[d][c]          = se[d][c][shead[d][c] % 64];
            end
        end
    end

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < CH; c++) begin
                if (in_p[d][c]) shead[d][c] <= shead[d][c] + 1;
            end
            if (onem[d] && opop[d]) begin
                rx_w[d][rx_cnt[d] % 128] <= {13'b0, ochan[d], oend[d], odat[d]};
                rx_cnt[d] <= rx_cnt[d] + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic pkt(input int d, input int c, input int n, input logic [W-1:0] base);
        for (int i = 0; i < n; i++) begin
            sd[d][c][slen[d][c]] = 16'(base + i + 1);
            se[d][c][slen[d][c]] = (i == n - 1);
            slen[d][c] = slen[d][c] + 1;
        end
    endtask

    task automatic expect_pkt(input int c, input int n, input logic [W-1:0] base, input int end_at);
        for (int i = 0; i < n; i++)
            exp_q.push_back({13'b0, 2'(c), (i == end_at), 16'(base + i + 1)});
    endtask

    task automatic sb(input string tag, input int d, input int b);
        chk({tag, "_count"}, rx_cnt[d] - b, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            chk(tag, rx_w[d][(b + i) % 128], exp_q[i]);
        exp_q.delete();
    endtask

    initial begin
        int b;
        rst_n   = 1'b0;
        ena[0]  = '1;
        ena[1]  = '1;
        opop[0] = 1'b1;
        opop[1] = 1'b1;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk1("rst_out_nempty", onem[d], 1'b0);
            chk("rst_out_data", 32'(odat[d]), 32'h0);
            chk1("rst_out_end", oend[d], 1'b0);
            chk("rst_out_channel", 32'(ochan[d]), 32'h0);
            chk("rst_trunc", 32'(trc[d]), 32'h0);
            chk("rst_in_pop", 32'(in_p[d]), 32'h0);
        end
        rst_n = 1'b1;

        // Single packet, channel 2, cycle-exact latency
        @(negedge clk);
        pkt(0, 2, 3, 16'h2000);
        #1 chk("single_idle_pop", 32'(in_p[0]), 32'h0);
        @(negedge clk);
        chk("single_pop", 32'(in_p[0]), 32'h4);
        chk1("single_nempty_n1", onem[0], 1'b0);
        @(negedge clk);
        chk1("single_nempty_n2", onem[0], 1'b1);
        chk("single_w1", 32'(odat[0]), 32'h2001);
        chk("single_chan", 32'(ochan[0]), 32'h2);
        chk1("single_end1", oend[0], 1'b0);
        @(negedge clk);
        chk("single_w2", 32'(odat[0]), 32'h2002);
        chk1("single_end2", oend[0], 1'b0);
        @(negedge clk);
        chk("single_w3", 32'(odat[0]), 32'h2003);
        chk1("single_end3", oend[0], 1'b1);
        @(negedge clk);
        chk1("single_drain", onem[0], 1'b0);

        // Round-robin from reset: 0, 1, 3, 0
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        b = rx_cnt[0];
        pkt(0, 0, 2, 16'h0010);
        pkt(0, 1, 2, 16'h1010);
        pkt(0, 3, 2, 16'h3010);
        pkt(0, 0, 2, 16'h0020);
        repeat (16) @(negedge clk);
        expect_pkt(0, 2, 16'h0010, 1);
        expect_pkt(1, 2, 16'h1010, 1);
        expect_pkt(3, 2, 16'h3010, 1);
        expect_pkt(0, 2, 16'h0020, 1);
        sb("rr_order", 0, b);

        // Backpressure mid-packet; 4-word packet ends exactly at MAX_WORDS
        b = rx_cnt[0];
        pkt(0, 1, 4, 16'h1100);
        repeat (2) @(negedge clk);
        chk("bp_first", 32'(odat[0]), 32'h1101);
        opop[0] = 1'b0;
        #1 chk("bp_pop_drop", 32'(in_p[0]), 32'h0);
        repeat (5) begin
            @(negedge clk);
            chk("bp_hold_pop", 32'(in_p[0]), 32'h0);
            chk1("bp_hold_valid", onem[0], 1'b1);
            chk("bp_hold_data", 32'(odat[0]), 32'h1101);
        end
        opop[0] = 1'b1;
        repeat (6) @(negedge clk);
        expect_pkt(1, 4, 16'h1100, 3);
        sb("bp_words", 0, b);
        chk("bp_no_trunc", 32'(trc[0]), 32'h0);

        // Oversize: 6 words with MAX_WORDS=4
        pkt(0, 2, 6, 16'h2200);
        repeat (4) @(negedge clk);
        chk("ovr_w3", 32'(odat[0]), 32'h2203);
        chk("ovr_trunc_before", 32'(trc[0]), 32'h0);
        @(negedge clk);
        chk("ovr_w4", 32'(odat[0]), 32'h2204);
        chk1("ovr_w4_end", oend[0], 1'b1);
        chk("ovr_trunc", 32'(trc[0]), 32'h1);
        chk("ovr_idle_pop", 32'(in_p[0]), 32'h0);
        @(negedge clk);
        chk1("ovr_gap", onem[0], 1'b0);
        chk("ovr_regrant_pop", 32'(in_p[0]), 32'h4);
        @(negedge clk);
        chk("ovr_w5", 32'(odat[0]), 32'h2205);
        chk1("ovr_w5_end", oend[0], 1'b0);
        @(negedge clk);
        chk("ovr_w6", 32'(odat[0]), 32'h2206);
        chk1("ovr_w6_end", oend[0], 1'b1);
        chk("ovr_trunc_after", 32'(trc[0]), 32'h1);

        // Disable during packet, then asynchronous reset mid-packet
        @(negedge clk);
        b = rx_cnt[0];
        pkt(0, 1, 3, 16'h1300);
        @(negedge clk);
        ena[0][1] = 1'b0;
        pkt(0, 1, 2, 16'h1400);
        chk("dis_busy_pop", 32'(in_p[0]), 32'h2);
        repeat (10) @(negedge clk);
        expect_pkt(1, 3, 16'h1300, 2);
        sb("dis_complete", 0, b);
        chk("dis_no_grant_pop", 32'(in_p[0]), 32'h0);
        chk1("dis_no_grant_out", onem[0], 1'b0);
        ena[0][1] = 1'b1;
        @(negedge clk);
        chk("ena_pop", 32'(in_p[0]), 32'h2);
        @(negedge clk);
        chk1("ena_valid", onem[0], 1'b1);
        chk("ena_w1", 32'(odat[0]), 32'h1401);
        #2 rst_n = 1'b0;
        #1;
        chk1("arst_nempty", onem[0], 1'b0);
        chk("arst_data", 32'(odat[0]), 32'h0);
        chk1("arst_end", oend[0], 1'b0);
        chk("arst_chan", 32'(ochan[0]), 32'h0);
        chk("arst_trunc", 32'(trc[0]), 32'h0);
        chk("arst_pop", 32'(in_p[0]), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fixed priority: 3 busy, 1 arrives, then 0 arrives
        b = rx_cnt[1];
        pkt(1, 3, 4, 16'h3300);
        repeat (2) @(negedge clk);
        pkt(1, 1, 2, 16'h3100);
        @(negedge clk);
        pkt(1, 0, 2, 16'h3000);
        repeat (12) @(negedge clk);
        expect_pkt(3, 4, 16'h3300, 3);
        expect_pkt(0, 2, 16'h3000, 1);
        expect_pkt(1, 2, 16'h3100, 1);
        sb("prio_order", 1, b);

        // Fixed priority keeps favouring channel 0 over a waiting channel 1
        b = rx_cnt[1];
        pkt(1, 0, 2, 16'h3020);
        pkt(1, 0, 2, 16'h3030);
        pkt(1, 1, 2, 16'h3120);
        repeat (12) @(negedge clk);
        expect_pkt(0, 2, 16'h3020, 1);
        expect_pkt(0, 2, 16'h3030, 1);
        expect_pkt(1, 2, 16'h3120, 1);
        sb("prio_starve", 1, b);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/packet_arbiter.md
# packet_arbiter

- Merges `CHANNELS` independent packet streams into one packet stream.
- Uses the codebase's show-ahead pop/nempty/data/end FIFO handshake on every side.
- Arbitration is packet-atomic: a granted channel keeps the output until its end word is forwarded.
- Sits between packet sources (camera RAM streamer, packet_rx replies, CPU-generated packets) and the 64-bit tx packet_fifo feeding net_ecp5.
- Replaces the single hard-wired source path; adds round-robin or fixed-priority mode, per-channel enables, an oversize-packet guard, and a source-channel tag.

## Interface
Parameters:
- `CHANNELS`, 4: number of input streams, 2..16
- `WORD_SIZE`, 64: data word width in bits
- `MODE`, 0: 0 = round-robin; 1 = fixed priority, channel 0 highest
- `MAX_WORDS`, 4096: packet length limit in words, ≥2

Ports:
- `clk` in 1: single clock for all logic
- `rst_n` in 1: asynchronous, active-low reset
- `in_nempty` in CHANNELS: per-channel word available
- `in_data` in CHANNELS*WORD_SIZE: channel c occupies bits [c*WORD_SIZE +: WORD_SIZE]
- `in_end` in CHANNELS: per-channel, current word is the last word of its packet
- `in_pop` out CHANNELS: per-channel pop, at most one bit high per cycle
- `chan_enable` in CHANNELS: channel eligible for a new grant
- `out_nempty` out 1: output word valid
- `out_data` out WORD_SIZE: output word
- `out_end` out 1: output word ends a packet
- `out_channel` out clog2(CHANNELS): source channel of the output word
- `out_pop` in 1: consumer takes the output word; ignored while out_nempty=0
- `trunc_count` out 16: saturating count of truncated packets

## Operation
- Output stage is one register: word, end, channel and valid.
  - Loads when `!out_nempty || out_pop`.
- FSM has two states, IDLE and BUSY.
- **IDLE**
  - Eligible channels are those with `chan_enable[c] && in_nempty[c]`.
  - With no eligible channel, remain in IDLE.
  - Otherwise latch the winner into `grant` and go to BUSY. No pop occurs in this cycle.
  - MODE 0 (round-robin): search from `last+1` upward with wrap; `last` resets to CHANNELS-1.
  - MODE 1 (fixed priority): lowest eligible index wins.
- **BUSY**
  - `in_pop[grant] = in_nempty[grant] && (!out_nempty || out_pop)`.
  - Each popped word loads the output register and increments `wcount`.
  - If the popped word has end=1: `last <= grant`, `wcount <= 0`, go to IDLE.
- **Oversize guard**
  - If the popped word is the MAX_WORDS-th word of the packet and `in_end=0`, it is forwarded with `out_end` forced to 1.
  - `trunc_count` increments, saturating at 16'hFFFF.
  - The grant is released exactly as for a normal end.
  - The channel's remaining words arrive later as a new packet.
- **Enables**
  - `chan_enable` is sampled only in IDLE.
  - Deasserting it during BUSY does not cut off the packet in flight.
- **Reset mid-packet**
  - All state clears and the output word is dropped.
  - Partially consumed input packets are not recovered; this is the upstream owner's concern.

## Timing
- Reset values: `in_pop`=0, `out_nempty`=0, `out_data`=0, `out_end`=0, `out_channel`=0, `trunc_count`=0, state IDLE, `last`=CHANNELS-1, `wcount`=0.
- Latency: first word is eligible in cycle N (IDLE), popped in N+1, and `out_nempty` is high in N+2.
- Throughput within a packet is 1 word/cycle while `out_pop` is held high and the source stays nempty.
- Gap between packets: one IDLE cycle after the end word is popped.
- `out_pop` together with a new load in the same cycle gives back-to-back valid words with no bubble.
- `out_data`, `out_end` and `out_channel` are stable while `out_nempty && !out_pop`.
- `in_pop` is combinational from registered state, `in_nempty` and `out_pop`. It has no path from `in_data` or `in_end`.
- Width rules:
  - `wcount` is clog2(MAX_WORDS+1) bits.
  - The end comparison is `wcount == MAX_WORDS-1` before the increment.

## Structure
- Shared package `packet_pkg`: WORD_SIZE default, MODE_RR/MODE_PRIO constants, FSM state encoding.
- Sub-module `rr_select` (combinational): takes `req[CHANNELS]`, `last` and `mode`, and returns `valid` plus `index`. It is reusable by the future rx demux.
- Top level holds the FSM, output register, word counter and truncation counter.

## Test plan
- **Single packet:** channel 2 presents 3 words (end on word 3), out_pop held 1.
  - out_channel=2; words arrive in cycles N+2..N+4.
  - out_end set only on the 3rd word.
- **Round-robin:** channels 0, 1 and 3 each have 2-word packets pending, MODE 0.
  - Output packet order is 0, 1, 3, 0, …
  - No interleaving of words within a packet.
- **Fixed priority:** MODE 1, channel 3 busy, channel 1 becomes ready mid-packet, then channel 0 becomes ready.
  - Channel 3 completes first, then 0, then 1.
- **Backpressure:** out_pop held 0 for 5 cycles mid-packet.
  - in_pop stays 0 and out_data is stable.
  - After release, no word is lost or duplicated, checked against a scoreboard.
- **Oversize:** MAX_WORDS=4, a 6-word packet.
  - 4th output word has out_end=1 and trunc_count=1.
  - Words 5–6 emerge as a separate 2-word packet.
- **Disable and reset:** chan_enable[1] drops during its packet and the packet completes; channel 1 gets no new grant while disabled. Then rst_n is pulsed low mid-packet.
  - All outputs return to their reset values asynchronously.
